// File: rtl/manta_bus_pkg.sv
// Shared types and default widths for the Manta core-chain bus arbiter.
package manta_bus_pkg;

  localparam int MANTA_ADDR_W = 16;
  localparam int MANTA_DATA_W = 16;

  typedef struct packed {
    logic [MANTA_ADDR_W-1:0] addr;
    logic [MANTA_DATA_W-1:0] data;
    logic                    rw;
  } bus_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/manta_bus_arbiter_rr.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// port that did not win last time. Purely combinational.
module rr_arbiter_2
  import manta_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant_onehot,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    case (req)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
    grant_onehot = (req == 2'b00) ? 2'b00 : idx_to_onehot(grant_idx);
  end

endmodule

// File: rtl/manta_bus_arbiter.sv
// Serializes two requesters onto the untagged Manta core chain, one transaction
// in flight, routing each echoed response (or a timeout error) to its issuer.
module manta_bus_arbiter
  import manta_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = MANTA_ADDR_W,
  parameter int DATA_WIDTH = MANTA_DATA_W,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_data,
  input  logic [1:0]              req_rw,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_data,
  output logic                    bus_rw,
  output logic                    bus_valid,
  input  logic [ADDR_WIDTH-1:0]   chain_addr,
  input  logic [DATA_WIDTH-1:0]   chain_data,
  input  logic                    chain_rw,
  input  logic                    chain_valid,
  output logic [1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Same layout as bus_req_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  rw;
  } req_fields_t;

  arb_state_t      state_q, state_d;
  req_fields_t     bus_q, bus_d;
  logic            bus_valid_q, bus_valid_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  logic [1:0]      win_onehot;
  logic            win_idx;
  req_fields_t     win_req;
  logic            chain_hit;
  logic            chain_rw_unused;

  // The chain echoes direction, but the address alone identifies the beat.
  assign chain_rw_unused = chain_rw;

  rr_arbiter_2 u_rr (
    .req          (req_valid),
    .last_grant   (last_grant_q),
    .grant_onehot (win_onehot),
    .grant_idx    (win_idx)
  );

  always_comb begin
    win_req.addr = req_addr[(win_idx ? ADDR_WIDTH : 0) +: ADDR_WIDTH];
    win_req.data = req_data[(win_idx ? DATA_WIDTH : 0) +: DATA_WIDTH];
    win_req.rw   = req_rw[win_idx];
  end

  assign chain_hit = chain_valid && (chain_addr == bus_q.addr);

  always_comb begin
    state_d      = state_q;
    bus_d        = bus_q;
    bus_valid_d  = 1'b0;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    resp_valid_d = 2'b00;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    req_ready    = 2'b00;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready    = win_onehot;
          bus_d        = win_req;
          grant_d      = win_idx;
          last_grant_d = win_idx;
          bus_valid_d  = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A matching beat beats a timeout firing in the same cycle.
        if (chain_hit) begin
          resp_valid_d = idx_to_onehot(grant_q);
          resp_data_d  = chain_data;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          resp_valid_d = idx_to_onehot(grant_q);
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bus_q        <= '0;
      bus_valid_q  <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_q        <= bus_d;
      bus_valid_q  <= bus_valid_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus_addr   = bus_q.addr;
  assign bus_data   = bus_q.data;
  assign bus_rw     = bus_q.rw;
  assign bus_valid  = bus_valid_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/manta_bus_arbiter.md
Name: manta_bus_arbiter

Overview:
- Shares the Manta core-chain bus (16-bit addr, 16-bit data, rw, valid) between two requesters, e.g. the Ethernet bridge (port 0) and a local requester such as an on-chip debug/UART bridge (port 1).
- Serializes transactions, one outstanding at a time, because the bus carries no transaction tag.
- Routes each core-chain response back to the requester that issued it.
- Times out lost responses so the chain can never hang.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 16, bus data width.
- TIMEOUT, 255, cycles to wait for a response before an error completion; must be ≥ 2.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port request accept.
- req_addr  in  2*ADDR_WIDTH  per-port address; port i is slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  2*DATA_WIDTH  per-port write data.
- req_rw  in  2  per-port direction; 1 = write, 0 = read.
- bus_addr  out  ADDR_WIDTH  to the core chain.
- bus_data  out  DATA_WIDTH  to the core chain.
- bus_rw  out  1  to the core chain.
- bus_valid  out  1  to the core chain.
- chain_addr  in  ADDR_WIDTH  response from the end of the chain.
- chain_data  in  DATA_WIDTH  response data.
- chain_rw  in  1  response direction.
- chain_valid  in  1  response valid.
- resp_valid  out  2  per-port one-cycle response strobe.
- resp_data  out  DATA_WIDTH  response data; shared by both ports, qualified by resp_valid.
- resp_err  out  1  timeout flag; qualified by resp_valid.
- busy  out  1  high whenever not IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, last_grant = 1 (so port 0 wins the first tie), timer = 0.
  - All outputs 0: req_ready, bus_*, resp_valid, resp_data, resp_err, busy.
  - An in-flight transaction is dropped; no response is ever delivered for it.
- State IDLE:
  - req_ready = 0.
  - If any req_valid is set, pick a winner:
    - only one port valid → that port;
    - both valid → the port that is not last_grant.
  - Register the winner's addr/data/rw onto bus_*, store grant = winner, set last_grant = winner.
  - Pulse req_ready[winner] combinationally in this same cycle; this is the accept handshake.
  - Go to ISSUE.
- State ISSUE (exactly 1 cycle):
  - bus_valid = 1.
  - Go to WAIT with timer = 0.
- State WAIT:
  - bus_valid = 0; bus_addr/data/rw hold their values.
  - Timer increments each cycle.
  - chain_valid = 1:
    - If chain_addr == latched bus_addr, next cycle: resp_valid[grant] = 1, resp_data = chain_data, resp_err = 0. Go to IDLE.
    - If chain_addr does not match, the beat is ignored.
  - Timer reaches TIMEOUT-1 with no matching response, next cycle: resp_valid[grant] = 1, resp_data = 0, resp_err = 1. Go to IDLE.
  - A matching chain_valid in the same cycle the timeout fires: the response wins and resp_err = 0.
- Responses:
  - Both reads and writes complete with a response, because the chain echoes writes.
  - For writes, resp_data = echoed chain_data.
- Latency:
  - Accept → bus_valid: 1 cycle.
  - chain_valid → resp_valid: 1 cycle.
  - Minimum back-to-back issue spacing: 3 cycles plus chain latency.
- Stray responses:
  - chain_valid while in IDLE or ISSUE is ignored; no resp_valid is generated.
- Fairness:
  - Under continuous contention the grants strictly alternate 0,1,0,1…
  - A single active port is granted on every IDLE with no penalty.
- Request rules:
  - req_valid deasserting before acceptance is legal; that request is then not issued.
  - The arbiter captures request fields only in the accept cycle.
- busy = (state != IDLE).
- Invariants:
  - resp_valid is one-hot or zero.
  - At most one outstanding transaction at any time.

Decomposition:
- Package manta_bus_pkg holds:
  - typedef bus_req_t {addr, data, rw};
  - typedef arb_state_t {IDLE, ISSUE, WAIT};
  - ADDR_WIDTH/DATA_WIDTH default constants.
- One natural sub-module: rr_arbiter_2.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_onehot[1:0], grant_idx.
  - Purely combinational; the top holds the FSM, timer and datapath registers.

Test Plan:
- Reset: hold rst_n low mid-WAIT with port 0 read to 0x0012 in flight → all outputs 0 immediately. After release, a chain_valid for 0x0012 produces no resp_valid.
- Single read: port 0 reads 0x0005; chain model returns data 0xBEEF 4 cycles after bus_valid.
  - bus_valid high exactly 1 cycle with addr 0x0005, rw 0.
  - resp_valid = 2'b01, resp_data = 0xBEEF, resp_err = 0, one cycle after chain_valid.
- Contention: both ports hold req_valid continuously; port 0 writes 0x0001/0x1111, port 1 writes 0x0002/0x2222.
  - Issue order: port 0, 1, 0, 1.
  - Each resp_valid goes only to the issuing port.
- Timeout with TIMEOUT = 8: port 1 reads 0x0033 and the chain never responds.
  - resp_valid = 2'b10, resp_err = 1, resp_data = 0, on the cycle after the 8th WAIT cycle.
  - The next request is accepted normally.
- Mismatch/stray responses:
  - chain_valid with addr 0x0099 during WAIT for 0x0005 is ignored; the later 0x0005 response completes.
  - chain_valid while IDLE produces no resp_valid.
- Timeout race: matching chain_valid in the same cycle the timeout fires → resp_err = 0 and resp_data = chain_data.
